// File: rtl/traffic_request_cond_if.sv
// ============================================================================
// traffic_request_cond_if : switch/ack inputs and request outputs of the conditioner
// Optional TRAFFIC_REQ_COUNT_EN adds req_count.  Rev 1.0
// ============================================================================
`default_nettype none

interface traffic_request_cond_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] SW;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] sw_clean;
`ifdef TRAFFIC_REQ_COUNT_EN
  logic [8*NUM_CH-1:0] req_count;

  modport master (output SW, output ack, input req, input sw_clean, input req_count);
  modport slave  (input SW, input ack, output req, output sw_clean, output req_count);
`else
  modport master (output SW, output ack, input req, input sw_clean);
  modport slave  (input SW, input ack, output req, output sw_clean);
`endif
endinterface

`default_nettype wire

// File: rtl/traffic_request_cond.sv
// ============================================================================
// traffic_request_cond : synchronise, debounce and latch switch presses as sticky requests
// Optional TRAFFIC_REQ_COUNT_EN adds 8-bit saturating accepted-request counters.  Rev 1.0
// ============================================================================
`default_nettype none

module traffic_request_cond #(
  parameter int NUM_CH    = 2,
  parameter int DB_CYCLES = 1000000
) (
  input wire clk,
  input wire rst_n,
  traffic_request_cond_if.slave bus
);

  localparam int               CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } req_state_t;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic             sync_meta;
    logic             sync;
    logic             clean;
    logic [CNT_W-1:0] db_cnt;
    logic             settle;
    logic             rise;
    req_state_t       state;
    logic             req_q;

    // settle: sync has disagreed with clean long enough to be adopted this edge
    assign settle = (sync != clean) && (db_cnt == CNT_LAST);
    assign rise   = settle && sync;

    always_ff @(posedge clk or negedge rst_n) begin : p_debounce
      if (!rst_n) begin
        sync_meta <= 1'b0;
        sync      <= 1'b0;
        clean     <= 1'b0;
        db_cnt    <= '0;
      end else begin
        sync_meta <= bus.SW[n];
        sync      <= sync_meta;
        if (sync == clean) begin
          db_cnt <= '0;
        end else if (settle) begin
          clean  <= sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end
    end

`ifdef TRAFFIC_REQ_COUNT_EN
    logic [7:0] req_cnt;

    always_ff @(posedge clk or negedge rst_n) begin : p_req_fsm
      if (!rst_n) begin
        state   <= IDLE;
        req_q   <= 1'b0;
        req_cnt <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= PEND;
              req_q <= 1'b1;
              if (req_cnt != 8'hFF) begin
                req_cnt <= req_cnt + 8'd1;
              end
            end
          end
          PEND: begin
            // A fresh press coinciding with ack re-arms the request
            if (!rise && bus.ack[n]) begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end

    assign bus.req_count[8*n +: 8] = req_cnt;
`else
    always_ff @(posedge clk or negedge rst_n) begin : p_req_fsm
      if (!rst_n) begin
        state <= IDLE;
        req_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= PEND;
              req_q <= 1'b1;
            end
          end
          PEND: begin
            // A fresh press coinciding with ack re-arms the request
            if (!rise && bus.ack[n]) begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
`endif

    assign bus.req[n]      = req_q;
    assign bus.sw_clean[n] = clean;
  end

endmodule

`default_nettype wire
